peripheral_apb4_requester: RTL and testbench
============================================

PERIPHERAL_APB4_REQUESTER -- requirements
Module: peripheral_apb4_requester

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width; legal values 8/16/32/64.
REQ-003 SHALL have parameter TIMEOUT, default 16, max wait-state cycles per transfer; 0 disables the timeout.
REQ-004 SHALL have port pclk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port presetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port cmd_valid, input, 1, command request.
REQ-007 SHALL have port cmd_ready, output, 1, command accepted.
REQ-008 SHALL have port cmd_write, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port cmd_addr, input, ADDR_WIDTH, target address.
REQ-010 SHALL have port cmd_wdata, input, DATA_WIDTH, write data.
REQ-011 SHALL have port cmd_strb, input, DATA_WIDTH/8, byte write strobes.
REQ-012 SHALL have port cmd_prot, input, 3, protection attributes.
REQ-013 SHALL have port rsp_valid, output, 1, response available.
REQ-014 SHALL have port rsp_ready, input, 1, response consumed.
REQ-015 SHALL have port rsp_rdata, output, DATA_WIDTH, read data.
REQ-016 SHALL have port rsp_err, output, 1, slave error or timeout.
REQ-017 SHALL have port rsp_timeout, output, 1, transfer aborted by timeout.
REQ-018 SHALL have APB outputs paddr (ADDR_WIDTH), pwrite (1), psel (1), penable (1), pwdata (DATA_WIDTH), pstrb (DATA_WIDTH/8), pprot (3).
REQ-019 SHALL have APB inputs pready (1), prdata (DATA_WIDTH), pslverr (1).

Function
REQ-020 SHALL implement the FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
REQ-021 IDLE: cmd_ready=1 and psel=0; cmd_valid&cmd_ready latches all cmd_* fields; next state is SETUP.
REQ-022 cmd_ready SHALL be 0 in every state except IDLE; no command is buffered beyond the latched one.
REQ-023 SETUP: psel=1, penable=0; paddr/pwrite/pwdata/pstrb/pprot driven from latched fields; next state is ACCESS unconditionally.
REQ-024 ACCESS: psel=1, penable=1; APB outputs held stable until completion.
REQ-025 In ACCESS with pready=1: capture prdata into rsp_rdata on reads (0 on writes) and pslverr into rsp_err; rsp_timeout=0; next state is RESP.
REQ-026 Wait counter SHALL clear on SETUP and count ACCESS cycles with pready=0; width is $clog2(TIMEOUT+1).
REQ-027 With TIMEOUT>0, on the TIMEOUT-th consecutive pready=0 ACCESS cycle: rsp_err=1, rsp_timeout=1, rsp_rdata=0; next state is RESP.
REQ-028 If pready=1 on the same cycle the timeout would fire, normal completion SHALL win.
REQ-029 RESP: psel=0, penable=0, rsp_valid=1, response fields stable until rsp_valid&rsp_ready; next state is IDLE.
REQ-030 pstrb SHALL be driven all-zero for reads regardless of cmd_strb.
REQ-031 Zero-wait latency: accept at cycle N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3, earliest next accept at N+4.
REQ-032 psel and penable SHALL be 0 whenever the FSM is in IDLE or RESP.

Reset
REQ-033 presetn=0 SHALL asynchronously force state IDLE, counter 0, and every output to 0 except cmd_ready, which is 1 once presetn is released.
REQ-034 Reset asserted mid-transfer SHALL abandon the transfer; no rsp_valid is produced for it.

Verification
REQ-035 Write addr 0x10, data 0xA5A5A5A5, strb 0xF, pready=1 -> SETUP/ACCESS each 1 cycle, pstrb=0xF, rsp_valid at N+3, rsp_err=0.
REQ-036 Read addr 0x20, pready low 3 cycles, prdata=0x12345678 -> rsp_rdata=0x12345678, pstrb=0, APB outputs stable across all waits.
REQ-037 TIMEOUT=4, pready held 0 -> abort after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-038 pready=1 exactly on the 4th wait cycle with TIMEOUT=4 -> normal completion, rsp_timeout=0.
REQ-039 pslverr=1 with pready=1; rsp_ready held 0 for 5 cycles -> rsp_err=1, rsp_valid and fields held, cmd_ready=0 throughout.
REQ-040 presetn pulsed low during ACCESS -> psel/penable=0 immediately, no response, next command completes normally.

Source files
------------

// File: rtl/peripheral_apb4_requester.sv
// APB4 requester: accepts one command at a time, runs the SETUP/ACCESS handshake
// with an optional wait-state timeout, and holds the response until consumed.
module peripheral_apb4_requester #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    pwrite,
  output logic                    psel,
  output logic                    penable,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e state_q, state_d;

  logic                  cmd_ready_q, cmd_ready_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0]     pstrb_q, pstrb_d;
  logic [2:0]            pprot_q, pprot_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                  timeout_hit_c;

  // Fires on the TIMEOUT-th consecutive unready ACCESS cycle; pready wins a tie.
  assign timeout_hit_c = (TIMEOUT > 0) && !pready &&
                         (wait_cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || timeout_hit_c) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for every registered output; handshake flags are decoded from state_d.
  always_comb begin
    cmd_ready_d   = (state_d == IDLE);
    psel_d        = (state_d == SETUP) || (state_d == ACCESS);
    penable_d     = (state_d == ACCESS);
    rsp_valid_d   = (state_d == RESP);
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_cnt_d    = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          pstrb_d  = cmd_write ? cmd_strb : '0;
          pprot_d  = cmd_prot;
        end
      end
      SETUP: wait_cnt_d = '0;
      ACCESS: begin
        if (pready) begin
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit_c) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else if (TIMEOUT > 0) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cmd_ready_q   <= 1'b1;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pprot       = pprot_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_peripheral_apb4_requester.sv
// Directed bench for peripheral_apb4_requester with TIMEOUT=4.
module tb_peripheral_apb4_requester;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic          pwrite, psel, penable, pready, pslverr;
  logic [DW-1:0] pwdata, prdata;
  logic [SW-1:0] pstrb;
  logic [2:0]    pprot;

  int n_tests = 0;
  int n_fail  = 0;

  peripheral_apb4_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, input logic [2:0] p);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_prot  = p;
  endtask

  initial begin
    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b1; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    #3;
    chk("rst_psel",      64'(psel),      64'd0);
    chk("rst_penable",   64'(penable),   64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    step(); step();
    presetn = 1'b1;
    step();
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("idle_paddr",     64'(paddr),     64'd0);

    // Zero-wait write
    issue(1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF, 3'd2);
    pready = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("wr_setup_psel",    64'(psel),      64'd1);
    chk("wr_setup_penable", 64'(penable),   64'd0);
    chk("wr_setup_ready",   64'(cmd_ready), 64'd0);
    chk("wr_paddr",         64'(paddr),     64'h10);
    chk("wr_pwdata",        64'(pwdata),    64'hA5A5_A5A5);
    chk("wr_pstrb",         64'(pstrb),     64'hF);
    chk("wr_pwrite",        64'(pwrite),    64'd1);
    chk("wr_pprot",         64'(pprot),     64'd2);
    step();
    chk("wr_access_penable", 64'(penable),   64'd1);
    chk("wr_access_valid",   64'(rsp_valid), 64'd0);
    step();
    chk("wr_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("wr_rsp_err",   64'(rsp_err),   64'd0);
    chk("wr_rsp_psel",  64'(psel),      64'd0);
    step();
    chk("wr_back_idle", 64'(cmd_ready), 64'd1);
    chk("wr_rsp_clear", 64'(rsp_valid), 64'd0);

    // Read with 3 wait states, completes on the 4th ACCESS cycle
    issue(1'b0, 32'h20, 32'hFFFF_FFFF, 4'hF, 3'd0);
    pready = 1'b0;
    step();
    cmd_valid = 1'b0;
    chk("rd_pstrb_zero", 64'(pstrb),  64'd0);
    chk("rd_pwrite",     64'(pwrite), 64'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait_penable", 64'(penable), 64'd1);
      chk("rd_wait_paddr",   64'(paddr),   64'h20);
      chk("rd_wait_valid",   64'(rsp_valid), 64'd0);
      step();
    end
    chk("rd_4th_penable", 64'(penable), 64'd1);
    pready = 1'b1; prdata = 32'h1234_5678;
    step();
    pready = 1'b0; prdata = '0;
    chk("rd_rsp_valid",   64'(rsp_valid),   64'd1);
    chk("rd_rsp_rdata",   64'(rsp_rdata),   64'h1234_5678);
    chk("rd_rsp_err",     64'(rsp_err),     64'd0);
    chk("rd_rsp_timeout", 64'(rsp_timeout), 64'd0);
    step();

    // Timeout: pready held low for 4 ACCESS cycles
    issue(1'b0, 32'h30, 32'h0, 4'h0, 3'd0);
    prdata = 32'hDEAD_BEEF;
    step();
    cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_penable", 64'(penable), 64'd1);
      step();
    end
    chk("to_rsp_valid",   64'(rsp_valid),   64'd1);
    chk("to_rsp_err",     64'(rsp_err),     64'd1);
    chk("to_rsp_timeout", 64'(rsp_timeout), 64'd1);
    chk("to_rsp_rdata",   64'(rsp_rdata),   64'd0);
    chk("to_psel",        64'(psel),        64'd0);
    step();
    prdata = '0;

    // Write with 3 waits, pready on the cycle the timeout would fire
    issue(1'b1, 32'h34, 32'h0000_BEEF, 4'h3, 3'd1);
    step();
    cmd_valid = 1'b0;
    chk("race_pstrb", 64'(pstrb), 64'h3);
    step(); step(); step(); step();
    chk("race_still_access", 64'(penable), 64'd1);
    pready = 1'b1;
    step();
    pready = 1'b0;
    chk("race_rsp_valid",   64'(rsp_valid),   64'd1);
    chk("race_rsp_timeout", 64'(rsp_timeout), 64'd0);
    chk("race_rsp_err",     64'(rsp_err),     64'd0);
    chk("race_rsp_rdata",   64'(rsp_rdata),   64'd0);
    step();

    // Slave error with response back-pressure
    issue(1'b1, 32'h40, 32'h5555_AAAA, 4'hF, 3'd0);
    pready = 1'b1; pslverr = 1'b1; rsp_ready = 1'b0;
    step();
    cmd_valid = 1'b0;
    step(); step();
    pslverr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("se_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("se_rsp_err",   64'(rsp_err),   64'd1);
      chk("se_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("se_psel",      64'(psel),      64'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("se_back_idle", 64'(cmd_ready), 64'd1);
    chk("se_rsp_clear", 64'(rsp_valid), 64'd0);

    // Reset during ACCESS abandons the transfer
    issue(1'b0, 32'h50, 32'h0, 4'h0, 3'd0);
    pready = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    chk("mr_access_penable", 64'(penable), 64'd1);
    #2 presetn = 1'b0;
    #1;
    chk("mr_psel_async",    64'(psel),    64'd0);
    chk("mr_penable_async", 64'(penable), 64'd0);
    step();
    presetn = 1'b1;
    step();
    chk("mr_no_rsp",    64'(rsp_valid), 64'd0);
    chk("mr_cmd_ready", 64'(cmd_ready), 64'd1);
    issue(1'b0, 32'h60, 32'h0, 4'h0, 3'd0);
    pready = 1'b1; prdata = 32'h0BAD_F00D;
    step();
    cmd_valid = 1'b0;
    step(); step();
    chk("mr_next_valid", 64'(rsp_valid), 64'd1);
    chk("mr_next_rdata", 64'(rsp_rdata), 64'h0BAD_F00D);
    chk("mr_next_err",   64'(rsp_err),   64'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
